// File: rtl/sys_cmd_master_if.sv
// sys_cmd_master_if: request, UART TX/RX and response signals of the command master
// master: the command initiator; slave: request source plus UART pair facing it
interface sys_cmd_master_if #(
  parameter int FRAME_WIDTH = 8,
  parameter int ALU_FUNC_WIDTH = 4,
  parameter int REG_FILE_ADDR_WIDTH = 4
);
  logic REQ_VALID;
  logic REQ_READY;
  logic [1:0] REQ_TYPE;
  logic [REG_FILE_ADDR_WIDTH-1:0] REQ_ADDR;
  logic [FRAME_WIDTH-1:0] REQ_DATA;
  logic [FRAME_WIDTH-1:0] REQ_OP_A;
  logic [FRAME_WIDTH-1:0] REQ_OP_B;
  logic [ALU_FUNC_WIDTH-1:0] REQ_FUNC;
  logic [FRAME_WIDTH-1:0] TX_P_DATA;
  logic TX_D_VLD;
  logic TX_BUSY;
  logic [FRAME_WIDTH-1:0] RX_P_DATA;
  logic RX_P_VLD;
  logic [15:0] RSP_DATA;
  logic RSP_VALID;
  logic RSP_TIMEOUT;
  logic BUSY;
  modport master (
    input REQ_VALID, REQ_TYPE, REQ_ADDR, REQ_DATA, REQ_OP_A, REQ_OP_B, REQ_FUNC,
    input TX_BUSY, RX_P_DATA, RX_P_VLD,
    output REQ_READY, TX_P_DATA, TX_D_VLD, RSP_DATA, RSP_VALID, RSP_TIMEOUT, BUSY
  );
  modport slave (
    output REQ_VALID, REQ_TYPE, REQ_ADDR, REQ_DATA, REQ_OP_A, REQ_OP_B, REQ_FUNC,
    output TX_BUSY, RX_P_DATA, RX_P_VLD,
    input REQ_READY, TX_P_DATA, TX_D_VLD, RSP_DATA, RSP_VALID, RSP_TIMEOUT, BUSY
  );
endinterface

// File: rtl/sys_cmd_master.sv
// sys_cmd_master: serializes one host request into a UART command frame and collects the response
// CLK/RST: clock and async active-high reset
// bus.REQ_*: request handshake and fields; bus.TX_*: byte stream to UART TX
// bus.RX_*: response bytes from UART RX; bus.RSP_*: result, completion and timeout pulses; bus.BUSY
module sys_cmd_master #(
  parameter int FRAME_WIDTH = 8,
  parameter int ALU_FUNC_WIDTH = 4,
  parameter int REG_FILE_ADDR_WIDTH = 4,
  parameter int RSP_TIMEOUT = 1024
) (
  input logic CLK,
  input logic RST,
  sys_cmd_master_if.master bus
);
  localparam int TW = $clog2(RSP_TIMEOUT);
  typedef enum logic [1:0] {IDLE, SEND, WAIT_RSP, DONE} state_t;
  state_t state;
  logic [1:0] typ, idx, last, rsp_n, rx_n;
  logic [3:0][FRAME_WIDTH-1:0] frm, req_frm;
  logic [FRAME_WIDTH-1:0] lo, hi, addr_b, func_b;
  logic [TW-1:0] tcnt;
  assign bus.REQ_READY = state == IDLE;
  assign bus.BUSY = state != IDLE;
  assign addr_b = {{(FRAME_WIDTH-REG_FILE_ADDR_WIDTH){1'b0}}, bus.REQ_ADDR};
  assign func_b = {{(FRAME_WIDTH-ALU_FUNC_WIDTH){1'b0}}, bus.REQ_FUNC};
  // The whole frame is built at accept so later request changes cannot leak in.
  always_comb begin
    req_frm[0] = bus.REQ_TYPE[1] ? (bus.REQ_TYPE[0] ? FRAME_WIDTH'(8'hDD) : FRAME_WIDTH'(8'hCC))
                                 : (bus.REQ_TYPE[0] ? FRAME_WIDTH'(8'hBB) : FRAME_WIDTH'(8'hAA));
    req_frm[1] = bus.REQ_TYPE == 2'b11 ? func_b : bus.REQ_TYPE == 2'b10 ? bus.REQ_OP_A : addr_b;
    req_frm[2] = bus.REQ_TYPE[1] ? bus.REQ_OP_B : bus.REQ_DATA;
    req_frm[3] = func_b;
  end
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
      typ <= '0;
      idx <= '0;
      last <= '0;
      rsp_n <= '0;
      rx_n <= '0;
      frm <= '0;
      lo <= '0;
      hi <= '0;
      tcnt <= '0;
      bus.TX_P_DATA <= '0;
      bus.TX_D_VLD <= 1'b0;
      bus.RSP_DATA <= '0;
      bus.RSP_VALID <= 1'b0;
      bus.RSP_TIMEOUT <= 1'b0;
    end else begin
      bus.RSP_VALID <= 1'b0;
      bus.RSP_TIMEOUT <= 1'b0;
      case (state)
        IDLE: if (bus.REQ_VALID) begin
          frm <= req_frm;
          typ <= bus.REQ_TYPE;
          idx <= '0;
          rx_n <= '0;
          last <= bus.REQ_TYPE == 2'b00 ? 2'd2 : bus.REQ_TYPE == 2'b10 ? 2'd3 : 2'd1;
          rsp_n <= bus.REQ_TYPE == 2'b00 ? 2'd0 : bus.REQ_TYPE == 2'b01 ? 2'd1 : 2'd2;
          bus.TX_P_DATA <= req_frm[0];
          bus.TX_D_VLD <= 1'b1;
          state <= SEND;
        end
        SEND: if (!bus.TX_BUSY) begin
          if (idx == last) begin
            bus.TX_D_VLD <= 1'b0;
            tcnt <= '0;
            state <= rsp_n == 2'd0 ? DONE : WAIT_RSP;
          end else begin
            idx <= idx + 2'd1;
            bus.TX_P_DATA <= frm[idx + 2'd1];
          end
        end
        WAIT_RSP: if (bus.RX_P_VLD) begin
          tcnt <= '0;
          if (rx_n == 2'd0) lo <= bus.RX_P_DATA;
          else hi <= bus.RX_P_DATA;
          rx_n <= rx_n + 2'd1;
          if (rx_n + 2'd1 == rsp_n) state <= DONE;
        end else if (tcnt == TW'(RSP_TIMEOUT - 1)) begin
          bus.RSP_TIMEOUT <= 1'b1;
          state <= IDLE;
        end else begin
          tcnt <= tcnt + 1'b1;
        end
        DONE: begin
          bus.RSP_DATA <= typ == 2'b00 ? 16'h0000 : typ == 2'b01 ? 16'(lo) : 16'({hi, lo});
          bus.RSP_VALID <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_sys_cmd_master.sv
// tb_sys_cmd_master: scoreboard bench for the UART command master
module tb_sys_cmd_master;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  int total = 0;
  int bad = 0;
  logic [7:0] tx_q[$];
  logic [16:0] rsp_q[$];
  logic [15:0] last_rsp = 16'h0000;
  sys_cmd_master_if bus();
  sys_cmd_master #(.RSP_TIMEOUT(16)) dut (.CLK(CLK), .RST(RST), .bus(bus));
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  always @(negedge CLK) if (!RST) begin
    if (bus.TX_D_VLD && !bus.TX_BUSY) begin
      if (tx_q.size() == 0) chk("tx_extra", 1, 0);
      else chk("tx_byte", bus.TX_P_DATA, tx_q.pop_front());
    end
    if (bus.RSP_VALID || bus.RSP_TIMEOUT) begin
      if (rsp_q.size() == 0) chk("rsp_extra", 1, 0);
      else begin
        logic [16:0] e;
        e = rsp_q.pop_front();
        chk("rsp_kind", {bus.RSP_TIMEOUT, bus.RSP_VALID}, e[16] ? 2'b10 : 2'b01);
        chk("rsp_data", bus.RSP_DATA, e[15:0]);
      end
    end
  end

  task automatic exp_rsp(input logic to, input logic [15:0] d);
    rsp_q.push_back({to, d});
    if (!to) last_rsp = d;
  endtask

  // Caller sits just after a rising edge; returns 1 ns into cycle 1 after accept.
  task automatic req(input logic [1:0] t, input logic [3:0] addr, input logic [7:0] d,
                     input logic [7:0] a, input logic [7:0] b, input logic [3:0] f);
    logic rdy;
    case (t)
      2'b00: begin tx_q.push_back(8'hAA); tx_q.push_back({4'h0, addr}); tx_q.push_back(d); end
      2'b01: begin tx_q.push_back(8'hBB); tx_q.push_back({4'h0, addr}); end
      2'b10: begin tx_q.push_back(8'hCC); tx_q.push_back(a); tx_q.push_back(b); tx_q.push_back({4'h0, f}); end
      default: begin tx_q.push_back(8'hDD); tx_q.push_back({4'h0, f}); end
    endcase
    bus.REQ_TYPE = t;
    bus.REQ_ADDR = addr;
    bus.REQ_DATA = d;
    bus.REQ_OP_A = a;
    bus.REQ_OP_B = b;
    bus.REQ_FUNC = f;
    bus.REQ_VALID = 1'b1;
    rdy = 1'b0;
    for (int i = 0; i < 100 && !rdy; i++) begin
      @(negedge CLK);
      rdy = bus.REQ_READY;
      @(posedge CLK);
    end
    if (!rdy) chk("req_accept", 0, 1);
    #1;
    bus.REQ_VALID = 1'b0;
    bus.REQ_TYPE = 2'($urandom);
    bus.REQ_ADDR = 4'($urandom);
    bus.REQ_DATA = 8'($urandom);
    bus.REQ_OP_A = 8'($urandom);
    bus.REQ_OP_B = 8'($urandom);
    bus.REQ_FUNC = 4'($urandom);
  endtask

  // Returns at the falling edge of the first cycle with TX_D_VLD low (WAIT_RSP entry).
  task automatic wait_tx_done();
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge CLK);
      seen = !bus.TX_D_VLD;
    end
    if (!seen) chk("tx_end", 0, 1);
  endtask

  task automatic rx_byte(input logic [7:0] b);
    bus.RX_P_DATA = b;
    bus.RX_P_VLD = 1'b1;
    @(posedge CLK);
    #1;
    bus.RX_P_VLD = 1'b0;
    bus.RX_P_DATA = 8'($urandom);
  endtask

  task automatic wait_idle();
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge CLK);
      ok = bus.REQ_READY && tx_q.size() == 0 && rsp_q.size() == 0;
    end
    if (!ok) chk("idle_wait", 0, 1);
    @(posedge CLK);
    #1;
  endtask

  initial begin
    int k;
    bus.REQ_VALID = 1'b0;
    bus.REQ_TYPE = '0;
    bus.REQ_ADDR = '0;
    bus.REQ_DATA = '0;
    bus.REQ_OP_A = '0;
    bus.REQ_OP_B = '0;
    bus.REQ_FUNC = '0;
    bus.TX_BUSY = 1'b0;
    bus.RX_P_DATA = '0;
    bus.RX_P_VLD = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    RST = 1'b0;
    @(negedge CLK);
    chk("rst_tx_data", bus.TX_P_DATA, 0);
    chk("rst_tx_vld", bus.TX_D_VLD, 0);
    chk("rst_rsp_data", bus.RSP_DATA, 0);
    chk("rst_pulses", {bus.RSP_VALID, bus.RSP_TIMEOUT}, 0);
    chk("rst_busy", bus.BUSY, 0);
    chk("rst_ready", bus.REQ_READY, 1);
    @(posedge CLK);
    #1;
    // write: bytes in cycles 1-3, RSP_VALID and READY in cycle 5
    exp_rsp(1'b0, 16'h0000);
    req(2'b00, 4'h5, 8'h3C, 8'h00, 8'h00, 4'h0);
    for (k = 1; k <= 5; k++) begin
      @(negedge CLK);
      chk($sformatf("wr_vld_c%0d", k), bus.TX_D_VLD, k <= 3);
      chk($sformatf("wr_rspv_c%0d", k), bus.RSP_VALID, k == 5);
      if (k == 4) chk("wr_busy_c4", bus.BUSY, 1);
      if (k == 5) chk("wr_ready_c5", bus.REQ_READY, 1);
    end
    wait_idle();
    // read with TX_BUSY held through cycles 1-3
    bus.TX_BUSY = 1'b1;
    exp_rsp(1'b0, 16'h0077);
    req(2'b01, 4'hA, 8'h00, 8'h00, 8'h00, 4'h0);
    for (k = 1; k <= 5; k++) begin
      @(negedge CLK);
      chk($sformatf("bp_vld_c%0d", k), bus.TX_D_VLD, 1);
      chk($sformatf("bp_data_c%0d", k), bus.TX_P_DATA, k < 5 ? 8'hBB : 8'h0A);
      if (k == 3) begin
        @(posedge CLK);
        #1;
        bus.TX_BUSY = 1'b0;
      end
    end
    wait_tx_done();
    @(posedge CLK);
    #1;
    rx_byte(8'h77);
    wait_idle();
    // ALU with operands
    exp_rsp(1'b0, 16'h0046);
    req(2'b10, 4'h0, 8'h00, 8'h12, 8'h34, 4'h2);
    wait_tx_done();
    @(posedge CLK);
    #1;
    rx_byte(8'h46);
    rx_byte(8'h00);
    wait_idle();
    // no-operand ALU with stray RX bytes in IDLE and SEND
    rx_byte(8'hEE);
    bus.TX_BUSY = 1'b1;
    exp_rsp(1'b0, 16'hABCD);
    req(2'b11, 4'h0, 8'h00, 8'h00, 8'h00, 4'h7);
    rx_byte(8'h5E);
    bus.TX_BUSY = 1'b0;
    wait_tx_done();
    @(posedge CLK);
    #1;
    rx_byte(8'hCD);
    @(posedge CLK);
    #1;
    rx_byte(8'hAB);
    wait_idle();
    // timeout: pulse 16 cycles after WAIT_RSP entry, RSP_DATA keeps ABCD
    exp_rsp(1'b1, last_rsp);
    req(2'b01, 4'h3, 8'h00, 8'h00, 8'h00, 4'h0);
    wait_tx_done();
    k = 0;
    while (!bus.RSP_TIMEOUT && k < 40) begin
      if (bus.RSP_VALID) chk("to_no_valid", 1, 0);
      @(negedge CLK);
      k++;
    end
    chk("to_latency", k, 16);
    wait_idle();
    // byte in the terminal cycle wins
    exp_rsp(1'b0, 16'h005A);
    req(2'b01, 4'h3, 8'h00, 8'h00, 8'h00, 4'h0);
    wait_tx_done();
    repeat (15) @(posedge CLK);
    #1;
    rx_byte(8'h5A);
    wait_idle();
    // abort during byte 2 of an ALU frame
    req(2'b10, 4'h0, 8'h00, 8'h21, 8'h43, 4'h9);
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b1;
    #1;
    chk("ab_tx_vld", bus.TX_D_VLD, 0);
    chk("ab_tx_data", bus.TX_P_DATA, 0);
    chk("ab_rsp_data", bus.RSP_DATA, 0);
    chk("ab_busy_ready", {bus.BUSY, bus.REQ_READY}, 2'b01);
    tx_q.delete();
    rsp_q.delete();
    last_rsp = 16'h0000;
    @(posedge CLK);
    #1;
    RST = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    chk("ab_no_pulse", {bus.RSP_VALID, bus.RSP_TIMEOUT}, 0);
    exp_rsp(1'b0, 16'h0099);
    req(2'b01, 4'h1, 8'h00, 8'h00, 8'h00, 4'h0);
    wait_tx_done();
    @(posedge CLK);
    #1;
    rx_byte(8'h99);
    wait_idle();
    exp_rsp(1'b0, 16'h0000);
    req(2'b00, 4'hF, 8'hA5, 8'h00, 8'h00, 4'h0);
    wait_idle();
    chk("txq_left", tx_q.size(), 0);
    chk("rspq_left", rsp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
